// File: rtl/vga_timing_pkg.sv
// Shared types and default 640x480@60 segment lengths for the raster timing generator.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } phase_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  function automatic int axis_total(input int a, input int f, input int s, input int b);
    return a + f + s + b;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with phase and sync registers that
// always reflect the decode of the registered count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FRONT  = DEF_H_FRONT,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BACK   = DEF_H_BACK,
  parameter bit POL    = 1'b0,
  parameter int CNT_W  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  output logic [CNT_W-1:0] count,
  output logic [1:0]       phase,
  output logic             sync,
  output logic             wrap
);

  localparam int TOTAL = axis_total(ACTIVE, FRONT, SYNC, BACK);

  if (ACTIVE < 1 || FRONT < 1 || SYNC < 1 || BACK < 1) begin : g_seg_chk
    $error("vga_axis_counter: every segment length must be at least 1");
  end
  if (longint'(TOTAL - 1) >= (longint'(1) << CNT_W)) begin : g_width_chk
    $error("vga_axis_counter: CNT_W too narrow for the axis total");
  end

  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] A_END = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] F_END = CNT_W'(ACTIVE + FRONT);
  localparam logic [CNT_W-1:0] S_END = CNT_W'(ACTIVE + FRONT + SYNC);

  function automatic phase_e decode(input logic [CNT_W-1:0] c);
    if (c < A_END)      return vga_timing_pkg::ACTIVE;
    else if (c < F_END) return vga_timing_pkg::FRONT;
    else if (c < S_END) return vga_timing_pkg::SYNC;
    else                return vga_timing_pkg::BACK;
  endfunction

  logic [CNT_W-1:0] count_nxt;
  phase_e           phase_nxt;
  phase_e           phase_q;

  assign wrap = adv && (count == LAST);

  // Phase follows the decode of the next count so it can never disagree with it.
  always_comb begin
    count_nxt = wrap ? '0 : count + 1'b1;
    phase_nxt = decode(count_nxt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      phase_q <= vga_timing_pkg::ACTIVE;
      sync    <= ~POL;
    end else if (adv) begin
      count   <= count_nxt;
      phase_q <= phase_nxt;
      sync    <= (phase_nxt == vga_timing_pkg::SYNC) ? POL : ~POL;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: horizontal/vertical counts, phases, syncs,
// registered video_on and combinational line/frame end strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CNT_W     = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en,
  output logic [CNT_W-1:0] x_count,
  output logic [CNT_W-1:0] y_count,
  output logic [1:0]       h_phase,
  output logic [1:0]       v_phase,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             line_end,
  output logic             frame_end
);

  localparam logic [CNT_W-1:0] H_ACT_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACTIVE - 1);

  logic h_wrap;
  logic v_wrap;
  logic h_act_nxt;
  logic v_act_nxt;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
    .POL(HSYNC_POL), .CNT_W(CNT_W)
  ) u_h (
    .clk(clk), .reset(reset), .adv(pix_en),
    .count(x_count), .phase(h_phase), .sync(hsync), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
    .POL(VSYNC_POL), .CNT_W(CNT_W)
  ) u_v (
    .clk(clk), .reset(reset), .adv(h_wrap),
    .count(y_count), .phase(v_phase), .sync(vsync), .wrap(v_wrap)
  );

  // Predict activity of the next position so video_on lands on the same edge as the counts.
  always_comb begin
    h_act_nxt = h_wrap || (x_count < H_ACT_LAST);
    v_act_nxt = (v_phase == ACTIVE);
    if (h_wrap) v_act_nxt = v_wrap || (y_count < V_ACT_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset)       video_on <= 1'b1;
    else if (pix_en) video_on <= h_act_nxt && v_act_nxt;
  end

  assign line_end  = h_wrap;
  assign frame_end = v_wrap;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator producing horizontal and vertical counts, sync pulses, active-video flag and line/frame strobes for the display pipeline. Replaces the separate fixed 640x480 line/frame counters with one block whose porch, sync and active lengths, sync polarity and pixel-rate enable are all parameters. Sits between the clock/reset source and the pixel renderer. Every output describes the pixel position currently held in the counters.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch, pixels
- `H_SYNC`, 96, hsync width, pixels
- `H_BACK`, 48, horizontal back porch, pixels
- `V_ACTIVE`, 480, visible lines per frame
- `V_FRONT`, 10, vertical front porch, lines
- `V_SYNC`, 2, vsync width, lines
- `V_BACK`, 33, vertical back porch, lines
- `HSYNC_POL`, 0, asserted level of hsync (0 = active-low)
- `VSYNC_POL`, 0, asserted level of vsync
- `CNT_W`, 10, width of count outputs
- `clk` in 1 — single clock; all state changes on its rising edge
- `reset` in 1 — synchronous, active-high
- `pix_en` in 1 — pixel-rate strobe; counters advance only on cycles where it is high
- `x_count` out CNT_W — current pixel within line, 0..H_TOTAL-1
- `y_count` out CNT_W — current line within frame, 0..V_TOTAL-1
- `h_phase` out 2 — horizontal phase (ACTIVE/FRONT/SYNC/BACK)
- `v_phase` out 2 — vertical phase
- `hsync` out 1 — horizontal sync, polarity per HSYNC_POL
- `vsync` out 1 — vertical sync, polarity per VSYNC_POL
- `video_on` out 1 — high when both phases are ACTIVE
- `line_end` out 1 — one-cycle pulse, last pixel of line being consumed
- `frame_end` out 1 — one-cycle pulse, last pixel of frame being consumed

## Operation
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise. Defaults give 800 x 525.
- Elaboration check: every segment >= 1; H_TOTAL-1 and V_TOTAL-1 fit in CNT_W.
- Horizontal: on `pix_en`, x increments; at H_TOTAL-1 it wraps to 0.
- Vertical: y advances only when x wraps. At V_TOTAL-1 it wraps to 0.
- Phase FSM per axis, on its own advance condition:
  - ACTIVE→FRONT when the count reaches ACTIVE
  - FRONT→SYNC at ACTIVE+FRONT
  - SYNC→BACK at ACTIVE+FRONT+SYNC
  - BACK→ACTIVE on wrap
- Phase registers must always equal the decode of the count. No illegal encodings are reachable.
- hsync is asserted (= HSYNC_POL) only in h_phase SYNC, otherwise it is ~HSYNC_POL. Same rule for vsync.
- `line_end` = `pix_en` & (x == H_TOTAL-1), combinational from the registered count.
- `frame_end` = `line_end` & (y == V_TOTAL-1).

## Timing
- Reset values:
  - x_count = 0, y_count = 0
  - phases ACTIVE
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL
  - video_on = 1 (position 0,0 is visible)
  - line_end = 0, frame_end = 0
- `reset` wins over `pix_en` in the same cycle. A reset mid-frame restarts at (0,0) on the next edge.
- Counts, phases, syncs and video_on are registers updated on the same edge, so they are mutually aligned with zero skew.
- Latency from a `pix_en` cycle to the new count appearing: 1 clk.
- With `pix_en` low, all registered outputs hold and the strobes are 0.
- Frame period: H_TOTAL*V_TOTAL `pix_en` strobes.

## Structure
- Package `vga_timing_pkg`:
  - `phase_e` enum: ACTIVE=0, FRONT=1, SYNC=2, BACK=3
  - default 640x480 segment constants
  - a total-length function
- Sub-module `vga_axis_counter`:
  - parameters ACTIVE/FRONT/SYNC/BACK/POL/CNT_W
  - ports: `clk`, `reset`, `adv` in, `count`, `phase`, `sync`, `wrap` out
  - instantiated twice: horizontal with adv = `pix_en`; vertical with adv = horizontal `wrap`
- Top level adds `video_on` and the strobes.

## Test plan
- Defaults, `pix_en`=1, reset held 3 cycles then released -> x runs 0..799 and wraps; `line_end` only at x=799; hsync low exactly for x=656..751.
- Defaults, full frame -> vsync low only for y=490..491; one `frame_end` at (799,524); 420000 clocks between `frame_end` pulses.
- `pix_en` high every 4th clk -> counts hold between strobes; line period 3200 clks; `line_end` coincides with a `pix_en` cycle.
- H 4/1/2/1, V 3/1/1/1, both POL=1 -> h_phase sequence ACTIVE x4, FRONT, SYNC x2, BACK; hsync high for x=5..6; video_on for x<4 and y<3 only.
- `reset` asserted at (300,200) with `pix_en`=1 -> next edge gives x=y=0, all outputs at reset values, no strobe.
- CNT_W too small (e.g. 9 with defaults) -> elaboration fails.
